csr_trap_unit: RTL and testbench

//  Parametrised exception/CSR unit: captures one trap from NUM_SRC pipeline sources, records

---
 rtl/csr_trap_unit.sv | 165 ++++++++++++++++
 tb/tb_csr_trap_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: captures one trap from prioritised sources, sequences the pipeline flush and
// the fetch redirect for traps and mret, and holds the machine trap CSRs plus a trap counter.
module csr_trap_unit #(
  parameter int               XLEN         = 32,
  parameter int               NUM_SRC      = 4,
  parameter int               CAUSE_W      = 5,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0]  MTVEC_RST    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         exc_valid,
  input  logic [NUM_SRC*XLEN-1:0]    exc_pc,
  input  logic [NUM_SRC*CAUSE_W-1:0] exc_cause,
  input  logic [NUM_SRC*XLEN-1:0]    exc_tval,
  input  logic                       mret,
  input  logic                       csr_en,
  input  logic                       csr_we,
  input  logic [11:0]                csr_addr,
  input  logic [XLEN-1:0]            csr_wdata,
  output logic [XLEN-1:0]            csr_rdata,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [XLEN-1:0]            redirect_pc,
  output logic                       busy,
  output logic [31:0]                exc_count
);

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  localparam int              CNT_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  mtvec_reg;
  logic [XLEN-1:0]  mepc_reg;
  logic [XLEN-1:0]  mcause_reg;
  logic [XLEN-1:0]  mtval_reg;
  logic [XLEN-1:0]  tgt_reg;

  logic [XLEN-1:0]    pc_arr    [NUM_SRC];
  logic [CAUSE_W-1:0] cause_arr [NUM_SRC];
  logic [XLEN-1:0]    tval_arr  [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign pc_arr[gi]    = exc_pc[gi*XLEN +: XLEN];
    assign cause_arr[gi] = exc_cause[gi*CAUSE_W +: CAUSE_W];
    assign tval_arr[gi]  = exc_tval[gi*XLEN +: XLEN];
  end

  logic [XLEN-1:0]    sel_pc;
  logic [CAUSE_W-1:0] sel_cause;
  logic [XLEN-1:0]    sel_tval;
  logic               exc_any;
  logic               csr_wr;

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    sel_pc    = '0;
    sel_cause = '0;
    sel_tval  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (exc_valid[i]) begin
        sel_pc    = pc_arr[i];
        sel_cause = cause_arr[i];
        sel_tval  = tval_arr[i];
      end
    end
  end

  assign exc_any = |exc_valid;
  assign csr_wr  = csr_en && csr_we && (state_reg == IDLE);

  always_comb begin
    csr_rdata = '0;
    if (csr_en) begin
      case (csr_addr)
        ADDR_MTVEC:  csr_rdata = mtvec_reg;
        ADDR_MEPC:   csr_rdata = mepc_reg;
        ADDR_MCAUSE: csr_rdata = mcause_reg;
        ADDR_MTVAL:  csr_rdata = mtval_reg;
        default:     csr_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      mtvec_reg      <= MTVEC_RST & ALIGN_MASK;
      mepc_reg       <= '0;
      mcause_reg     <= '0;
      mtval_reg      <= '0;
      tgt_reg        <= '0;
      exc_count      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // mtvec may be written alongside a trap; tgt still takes the old vector.
          if (csr_wr && csr_addr == ADDR_MTVEC) mtvec_reg <= csr_wdata & ALIGN_MASK;
          if (exc_any) begin
            mepc_reg   <= sel_pc & ALIGN_MASK;
            mcause_reg <= {{(XLEN-CAUSE_W){1'b0}}, sel_cause};
            mtval_reg  <= sel_tval;
            tgt_reg    <= mtvec_reg;
            if (exc_count != 32'hFFFF_FFFF) exc_count <= exc_count + 32'd1;
          end else if (csr_wr) begin
            case (csr_addr)
              ADDR_MEPC:   mepc_reg   <= csr_wdata & ALIGN_MASK;
              ADDR_MCAUSE: mcause_reg <= csr_wdata;
              ADDR_MTVAL:  mtval_reg  <= csr_wdata;
              default:     ;
            endcase
          end
          if (!exc_any && mret) tgt_reg <= mepc_reg;
          if (exc_any || mret) begin
            state_reg <= FLUSH;
            cnt_reg   <= CNT_INIT;
            flush     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg      <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= tgt_reg;
          end else begin
            cnt_reg <= cnt_reg - CNT_LAST;
          end
        end
        REDIRECT: begin
          state_reg      <= IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          busy           <= 1'b0;
        end
        default: begin
          state_reg      <= IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed vector table, hand-written corner sequences, then
// randomized traffic checked against a cycle-countdown reference model.
module tb_csr_trap_unit;
  localparam int FC = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   exc_valid;
  logic [127:0] exc_pc;
  logic [19:0]  exc_cause;
  logic [127:0] exc_tval;
  logic         mret, csr_en, csr_we;
  logic [11:0]  csr_addr;
  logic [31:0]  csr_wdata, csr_rdata;
  logic         flush, redirect_valid, busy;
  logic [31:0]  redirect_pc, exc_count;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  csr_trap_unit #(
    .XLEN(32), .NUM_SRC(4), .CAUSE_W(5), .FLUSH_CYCLES(FC), .MTVEC_RST(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .exc_cause(exc_cause), .exc_tval(exc_tval), .mret(mret), .csr_en(csr_en),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .exc_count(exc_count)
  );

  typedef struct {
    logic [3:0]  ev;
    logic        mr;
    logic [31:0] mtvec_w;
    logic [31:0] mepc_w;
    logic [31:0] exp_tgt;
    logic [31:0] exp_mepc;
    logic [31:0] exp_cause;
    int          counted;
  } vec_t;

  vec_t tab [6];

  // reference model state
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_cnt, m_tgt, m_rpc;
  int          m_left;
  int          exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    exc_valid = '0; mret = 1'b0; csr_en = 1'b0; csr_we = 1'b0;
    csr_addr = '0; csr_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_en = 1'b1; csr_we = 1'b0; csr_addr = a;
    #1 v = csr_rdata;
    csr_en = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_en = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    idle_inputs();
  endtask

  task automatic set_sources();
    exc_pc    = {32'h300, 32'h280, 32'h200, 32'h100};
    exc_cause = {5'd9, 5'd7, 5'd5, 5'd2};
    exc_tval  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  endtask

  // Skip the flush cycles after the request edge and check the redirect cycle.
  task automatic expect_redirect(input string name, input logic [31:0] tgt);
    for (int c = 1; c < FC; c++) tick();
    tick();
    chk({name, " redirect_valid"}, {31'd0, redirect_valid}, 32'd1);
    chk({name, " redirect_pc"}, redirect_pc, tgt);
    tick();
  endtask

  function automatic logic [31:0] model_rd(input logic en, input logic [11:0] a);
    if (!en) return 32'd0;
    case (a)
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    logic [3:0]  ev;
    logic        mr, en, we;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] pcs [4];
    logic [31:0] tvs [4];
    logic [4:0]  cs  [4];
    logic [11:0] addrs [5];

    tab[0] = '{4'b0001, 1'b0, 32'h8000, 32'h0,   32'h8000, 32'h100, 32'd2, 1};
    tab[1] = '{4'b1010, 1'b0, 32'h8000, 32'h0,   32'h8000, 32'h200, 32'd5, 1};
    tab[2] = '{4'b0000, 1'b1, 32'h8000, 32'h104, 32'h104,  32'h104, 32'd5, 0};
    tab[3] = '{4'b0100, 1'b1, 32'h9000, 32'h0,   32'h9000, 32'h280, 32'd7, 1};
    tab[4] = '{4'b1000, 1'b0, 32'h8003, 32'h0,   32'h8000, 32'h300, 32'd9, 1};
    tab[5] = '{4'b0000, 1'b1, 32'h8000, 32'h107, 32'h104,  32'h104, 32'd9, 0};
    addrs  = '{12'h305, 12'h341, 12'h343, 12'h342, 12'h7C0};

    idle_inputs();
    set_sources();
    reset = 1'b0;
    tick(); tick();
    chk("reset flush", {31'd0, flush}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    chk("reset exc_count", exc_count, 32'd0);
    reset = 1'b1;
    tick();
    exp_cnt = 0;

    // Directed table: set mtvec/mepc, issue the request, verify exact timing and capture.
    for (int t = 0; t < 6; t++) begin
      wr(12'h305, tab[t].mtvec_w);
      wr(12'h341, tab[t].mepc_w);
      exc_valid = tab[t].ev; mret = tab[t].mr;
      tick();
      idle_inputs();
      exp_cnt += tab[t].counted;
      for (int c = 1; c <= FC; c++) begin
        chk($sformatf("tab%0d flush c%0d", t, c), {31'd0, flush}, 32'd1);
        chk($sformatf("tab%0d early redirect c%0d", t, c), {31'd0, redirect_valid}, 32'd0);
        tick();
      end
      chk($sformatf("tab%0d redirect_valid", t), {31'd0, redirect_valid}, 32'd1);
      chk($sformatf("tab%0d redirect_pc", t), redirect_pc, tab[t].exp_tgt);
      chk($sformatf("tab%0d flush at redirect", t), {31'd0, flush}, 32'd1);
      tick();
      chk($sformatf("tab%0d idle busy", t), {31'd0, busy}, 32'd0);
      chk($sformatf("tab%0d idle redirect_valid", t), {31'd0, redirect_valid}, 32'd0);
      chk($sformatf("tab%0d pc hold", t), redirect_pc, tab[t].exp_tgt);
      rd(12'h341, v); chk($sformatf("tab%0d mepc", t), v, tab[t].exp_mepc);
      rd(12'h342, v); chk($sformatf("tab%0d mcause", t), v, tab[t].exp_cause);
      chk($sformatf("tab%0d exc_count", t), exc_count, exp_cnt);
    end

    // Requests while busy are dropped: single redirect, single count.
    exc_valid = 4'b0001;
    tick();
    exc_valid = 4'b0100;
    tick();
    exc_valid = 4'b0000; mret = 1'b1;
    chk("busy drop early redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    idle_inputs();
    exp_cnt++;
    chk("busy drop redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("busy drop redirect_pc", redirect_pc, 32'h8000);
    tick();
    chk("busy drop no second seq", {31'd0, busy}, 32'd0);
    tick();
    chk("busy drop still idle", {31'd0, flush}, 32'd0);
    chk("busy drop exc_count", exc_count, exp_cnt);
    rd(12'h341, v); chk("busy drop mepc", v, 32'h100);

    // CSR write while busy ignored; unmapped and disabled reads return zero.
    exc_valid = 4'b0001;
    tick();
    idle_inputs();
    exp_cnt++;
    wr(12'h305, 32'h4000);
    tick();
    tick();
    rd(12'h305, v); chk("busy write mtvec", v, 32'h8000);
    rd(12'h7C0, v); chk("unmapped read", v, 32'd0);
    csr_en = 1'b0; csr_addr = 12'h305;
    #1 chk("csr_en low read", csr_rdata, 32'd0);

    // Trap capture beats same-cycle mepc write.
    exc_valid = 4'b0010; csr_en = 1'b1; csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h5550;
    tick();
    idle_inputs();
    exp_cnt++;
    expect_redirect("cap vs mepc wr", 32'h8000);
    rd(12'h341, v); chk("cap vs mepc wr mepc", v, 32'h200);

    // Same-cycle mtvec write lands, but the redirect uses the old vector.
    exc_valid = 4'b0001; csr_en = 1'b1; csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'hA000;
    tick();
    idle_inputs();
    exp_cnt++;
    expect_redirect("mtvec same cycle", 32'h8000);
    rd(12'h305, v); chk("mtvec same cycle new", v, 32'hA000);
    chk("mtvec same cycle count", exc_count, exp_cnt);

    // Reset during FLUSH: immediate clear, no redirect afterwards.
    exc_valid = 4'b0001;
    tick();
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("mid reset flush", {31'd0, flush}, 32'd0);
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset exc_count", exc_count, 32'd0);
    chk("mid reset redirect_pc", redirect_pc, 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < FC + 2; c++) begin
      tick();
      chk($sformatf("mid reset no redirect c%0d", c), {31'd0, redirect_valid}, 32'd0);
    end
    rd(12'h305, v); chk("mid reset mtvec", v, 32'd0);
    rd(12'h341, v); chk("mid reset mepc", v, 32'd0);
    rd(12'h342, v); chk("mid reset mcause", v, 32'd0);
    rd(12'h343, v); chk("mid reset mtval", v, 32'd0);

    // Randomized traffic against the reference model.
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cnt = 0; m_tgt = 0; m_rpc = 0;
    m_left = 0;
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < 4; s++) begin
        pcs[s] = $urandom; tvs[s] = $urandom; cs[s] = 5'($urandom);
      end
      ev   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      mr   = ($urandom_range(0, 5) == 0);
      en   = 1'($urandom);
      we   = 1'($urandom);
      addr = addrs[$urandom_range(0, 4)];
      wd   = $urandom;
      if (addr == 12'h342) we = 1'b0;
      exc_pc    = {pcs[3], pcs[2], pcs[1], pcs[0]};
      exc_tval  = {tvs[3], tvs[2], tvs[1], tvs[0]};
      exc_cause = {cs[3], cs[2], cs[1], cs[0]};
      exc_valid = ev; mret = mr; csr_en = en; csr_we = we; csr_addr = addr; csr_wdata = wd;
      #1 chk($sformatf("rand%0d csr_rdata", n), csr_rdata, model_rd(en, addr));

      if (m_left > 0) begin
        m_left--;
      end else begin
        logic [31:0] new_mtvec;
        new_mtvec = m_mtvec;
        if (en && we && addr == 12'h305) new_mtvec = wd & 32'hFFFF_FFFC;
        if (ev != 0) begin
          int idx;
          idx = 0;
          while (!ev[idx]) idx++;
          m_mepc   = pcs[idx] & 32'hFFFF_FFFC;
          m_mcause = {27'd0, cs[idx]};
          m_mtval  = tvs[idx];
          m_tgt    = m_mtvec;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
          m_left = FC + 1;
        end else begin
          if (mr) begin
            m_tgt  = m_mepc;
            m_left = FC + 1;
          end
          if (en && we && addr == 12'h341) m_mepc = wd & 32'hFFFF_FFFC;
          if (en && we && addr == 12'h343) m_mtval = wd;
        end
        m_mtvec = new_mtvec;
      end
      if (m_left == 1) m_rpc = m_tgt;

      tick();
      chk($sformatf("rand%0d flush", n), {31'd0, flush}, {31'd0, m_left > 0});
      chk($sformatf("rand%0d busy", n), {31'd0, busy}, {31'd0, m_left > 0});
      chk($sformatf("rand%0d redirect_valid", n), {31'd0, redirect_valid}, {31'd0, m_left == 1});
      chk($sformatf("rand%0d redirect_pc", n), redirect_pc, m_rpc);
      chk($sformatf("rand%0d exc_count", n), exc_count, m_cnt);
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
